// File: rtl/inst_scheduler_pkg.sv
// inst_scheduler_pkg
// Shared types and constants for the out-of-order issue queue.
//   RegType_t / RegFile_t : operand / destination tag (register class + address)
//   ExeUnit_t             : execution unit an instruction is steered to
//   ExeBusy_t             : one busy bit per real execution unit
//   IqEntry_t             : one issue-queue slot
package inst_scheduler_pkg;

    localparam int IqDepth  = 4;
    localparam int RobDepth = 32;

    // Active-low enables used on the handshake ports.
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;

    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        TYPE_GPR  = 3'd1,
        TYPE_FPR  = 3'd2,
        TYPE_ROB  = 3'd3,
        TYPE_PC   = 3'd4,
        TYPE_IMM  = 3'd5
    } RegType_t;

    typedef struct packed {
        RegType_t   regtype;
        logic [4:0] addr;
    } RegFile_t;

    typedef enum logic [2:0] {
        UNIT_NOP  = 3'd0,
        UNIT_ALU  = 3'd1,
        UNIT_DIV  = 3'd2,
        UNIT_FPU  = 3'd3,
        UNIT_FDIV = 3'd4,
        UNIT_MEM  = 3'd5
    } ExeUnit_t;

    typedef struct packed {
        logic mem;
        logic fdiv;
        logic fpu;
        logic div;
        logic alu;
    } ExeBusy_t;

    typedef struct packed {
        logic     valid;
        RegFile_t rd;
        RegFile_t rs1;
        RegFile_t rs2;
        logic     rdy1;
        logic     rdy2;
        ExeUnit_t unit;
    } IqEntry_t;

    // A NOP has no execution unit behind it, so it is never blocked.
    function automatic logic unit_busy(input ExeBusy_t busy, input ExeUnit_t unit);
        case (unit)
            UNIT_ALU:  return busy.alu;
            UNIT_DIV:  return busy.div;
            UNIT_FPU:  return busy.fpu;
            UNIT_FDIV: return busy.fdiv;
            UNIT_MEM:  return busy.mem;
            default:   return 1'b0;
        endcase
    endfunction

    // Only ROB-renamed operands can still be in flight; every other class
    // (GPR, FPR, PC, IMM, NONE) is available at dispatch.
    function automatic logic ready_at_dispatch(input RegFile_t src, input logic ready);
        return ready || (src.regtype != TYPE_ROB);
    endfunction

endpackage

// File: rtl/iq_select.sv
// iq_select
// Lowest-index priority encoder.
//   req   : request vector, bit i = slot i eligible
//   found : at least one request is set
//   idx   : index of the lowest set request (0 when none)
module iq_select #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/inst_scheduler.sv
// inst_scheduler
// Out-of-order issue queue between rename/dispatch and the execution units.
// Holds IQ_DEPTH renamed instructions, wakes their operands on writeback,
// ALU forwarding and commit, and issues the lowest-index ready instruction
// whose execution unit is not busy, at most one per cycle.
//   clk, reset                 : clock, asynchronous active-high reset
//   flush_                     : active-low, invalidate all entries
//   add_entry_, ren_*, dec_*   : active-low dispatch of one entry into dec_iq_id
//   exe_busy                   : per-unit busy bits
//   wb_e_, wb_rd               : active-low writeback of a destination tag
//   commit_e_, commit_rob_id   : active-low commit of a ROB entry
//   issue_*                    : issued entry (combinational from queue state)
module inst_scheduler
    import inst_scheduler_pkg::*;
#(
    parameter  int IQ_DEPTH  = IqDepth,
    parameter  int ROB_DEPTH = RobDepth,
    localparam int IQ  = $clog2(IQ_DEPTH),
    localparam int ROB = $clog2(ROB_DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush_,
    input  logic           add_entry_,
    input  RegFile_t       ren_rd,
    input  RegFile_t       ren_rs1,
    input  logic           ren_rs1_ready,
    input  RegFile_t       ren_rs2,
    input  logic           ren_rs2_ready,
    input  ExeUnit_t       dec_unit,
    input  logic [IQ-1:0]  dec_iq_id,
    input  ExeBusy_t       exe_busy,
    input  logic           wb_e_,
    input  RegFile_t       wb_rd,
    input  logic           commit_e_,
    input  RegFile_t       commit_rd,
    input  logic [ROB-1:0] commit_rob_id,
    output logic           issue_e_,
    output logic [IQ-1:0]  issue_iq_id,
    output RegFile_t       issue_rd,
    output RegFile_t       issue_rs1,
    output RegFile_t       issue_rs2,
    output ExeUnit_t       issue_unit
);

    IqEntry_t [IQ_DEPTH-1:0] entries;
    logic     [IQ_DEPTH-1:0] eligible;
    logic                    sel_found;
    logic     [IQ-1:0]       sel_idx;
    IqEntry_t                sel_entry;
    logic                    fwd_valid;
    RegFile_t                fwd_rd;

    // The committing architectural register is not needed for wakeup.
    logic unused_commit_rd;
    assign unused_commit_rd = ^commit_rd;

    // The entry leaving this cycle broadcasts its tag when it is a
    // single-cycle ALU op; its consumers become eligible on the next cycle,
    // exactly when the result comes off the ALU bypass.
    assign sel_entry = entries[sel_idx];
    assign fwd_valid = sel_found && (sel_entry.unit == UNIT_ALU)
                       && (sel_entry.rd.regtype == TYPE_ROB);
    assign fwd_rd    = sel_entry.rd;

    function automatic logic woken(input RegFile_t src);
        return ((wb_e_ == Enable_) && (src == wb_rd))
            || (fwd_valid && (src == fwd_rd))
            || ((commit_e_ == Enable_) && (src.regtype == TYPE_ROB)
                && (ROB'(src.addr) == commit_rob_id));
    endfunction

    generate
        for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_entry
            IqEntry_t ent_reg;
            IqEntry_t ent_next;

            always_comb begin
                ent_next      = ent_reg;
                ent_next.rdy1 = ent_reg.rdy1 | woken(ent_reg.rs1);
                ent_next.rdy2 = ent_reg.rdy2 | woken(ent_reg.rs2);
                if (sel_found && (sel_idx == IQ'(gi))) begin
                    ent_next.valid = 1'b0;
                end
                // A dispatch into the slot being issued replaces it.
                if ((add_entry_ == Enable_) && (dec_iq_id == IQ'(gi))) begin
                    ent_next.valid = 1'b1;
                    ent_next.rd    = ren_rd;
                    ent_next.rs1   = ren_rs1;
                    ent_next.rs2   = ren_rs2;
                    ent_next.unit  = dec_unit;
                    ent_next.rdy1  = ready_at_dispatch(ren_rs1, ren_rs1_ready) | woken(ren_rs1);
                    ent_next.rdy2  = ready_at_dispatch(ren_rs2, ren_rs2_ready) | woken(ren_rs2);
                end
                if (flush_ == Enable_) begin
                    ent_next.valid = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ent_reg <= '0;
                end else begin
                    ent_reg <= ent_next;
                end
            end

            assign entries[gi]  = ent_reg;
            assign eligible[gi] = ent_reg.valid && ent_reg.rdy1 && ent_reg.rdy2
                                  && !unit_busy(exe_busy, ent_reg.unit);
        end
    endgenerate

    iq_select #(
        .N (IQ_DEPTH)
    ) u_select (
        .req   (eligible),
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_comb begin
        issue_e_    = Disable_;
        issue_iq_id = '0;
        issue_rd    = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        issue_unit  = UNIT_NOP;
        if (sel_found) begin
            issue_e_    = Enable_;
            issue_iq_id = sel_idx;
            issue_rd    = sel_entry.rd;
            issue_rs1   = sel_entry.rs1;
            issue_rs2   = sel_entry.rs2;
            issue_unit  = sel_entry.unit;
        end
    end

endmodule

// File: tb/tb_inst_scheduler.sv
// tb_inst_scheduler
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model that tracks, per slot, which source tags are still
// outstanding and picks the first slot with nothing outstanding.
module tb_inst_scheduler;
    import inst_scheduler_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           flush_ = 1'b1;
    logic           add_entry_ = 1'b1;
    RegFile_t       ren_rd = '0;
    RegFile_t       ren_rs1 = '0;
    logic           ren_rs1_ready = 1'b0;
    RegFile_t       ren_rs2 = '0;
    logic           ren_rs2_ready = 1'b0;
    ExeUnit_t       dec_unit = UNIT_NOP;
    logic [1:0]     dec_iq_id = '0;
    ExeBusy_t       exe_busy = '0;
    logic           wb_e_ = 1'b1;
    RegFile_t       wb_rd = '0;
    logic           commit_e_ = 1'b1;
    RegFile_t       commit_rd = '0;
    logic [4:0]     commit_rob_id = '0;
    logic           issue_e_;
    logic [1:0]     issue_iq_id;
    RegFile_t       issue_rd;
    RegFile_t       issue_rs1;
    RegFile_t       issue_rs2;
    ExeUnit_t       issue_unit;

    int n_checks = 0;
    int n_errors = 0;

    inst_scheduler #(.IQ_DEPTH(4), .ROB_DEPTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_        (flush_),
        .add_entry_    (add_entry_),
        .ren_rd        (ren_rd),
        .ren_rs1       (ren_rs1),
        .ren_rs1_ready (ren_rs1_ready),
        .ren_rs2       (ren_rs2),
        .ren_rs2_ready (ren_rs2_ready),
        .dec_unit      (dec_unit),
        .dec_iq_id     (dec_iq_id),
        .exe_busy      (exe_busy),
        .wb_e_         (wb_e_),
        .wb_rd         (wb_rd),
        .commit_e_     (commit_e_),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .issue_e_      (issue_e_),
        .issue_iq_id   (issue_iq_id),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_unit    (issue_unit)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit       m_valid [4];
    bit       m_wait1 [4];   // source 1 still outstanding
    bit       m_wait2 [4];
    RegFile_t m_rd    [4];
    RegFile_t m_rs1   [4];
    RegFile_t m_rs2   [4];
    ExeUnit_t m_unit  [4];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic RegFile_t mk(input RegType_t t, input int a);
        RegFile_t r;
        r.regtype = t;
        r.addr    = 5'(a);
        return r;
    endfunction

    function automatic bit unit_blocked(input ExeUnit_t u);
        if (u == UNIT_ALU)  return exe_busy.alu;
        if (u == UNIT_DIV)  return exe_busy.div;
        if (u == UNIT_FPU)  return exe_busy.fpu;
        if (u == UNIT_FDIV) return exe_busy.fdiv;
        if (u == UNIT_MEM)  return exe_busy.mem;
        return 1'b0;
    endfunction

    function automatic int predict_slot();
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && !m_wait1[i] && !m_wait2[i] && !unit_blocked(m_unit[i])) return i;
        end
        return -1;
    endfunction

    // Does anything broadcast this tag during the current cycle?
    function automatic bit tag_seen(input RegFile_t t, input bit fwd, input RegFile_t ft);
        if (!wb_e_ && t == wb_rd) return 1'b1;
        if (fwd && t == ft) return 1'b1;
        if (!commit_e_ && t.regtype == TYPE_ROB && t.addr == commit_rob_id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_wait1[i] = 1'b0;
            m_wait2[i] = 1'b0;
        end
    endtask

    // Apply one clock edge using the inputs that were present before it.
    task automatic model_update(input int pi);
        bit       fwd;
        RegFile_t ft;
        int       k;
        fwd = 1'b0;
        ft  = '0;
        if (pi >= 0) begin
            fwd = (m_unit[pi] == UNIT_ALU) && (m_rd[pi].regtype == TYPE_ROB);
            ft  = m_rd[pi];
        end
        if (!flush_) begin
            for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_wait1[i] && tag_seen(m_rs1[i], fwd, ft)) m_wait1[i] = 1'b0;
            if (m_wait2[i] && tag_seen(m_rs2[i], fwd, ft)) m_wait2[i] = 1'b0;
        end
        if (pi >= 0) m_valid[pi] = 1'b0;
        if (!add_entry_) begin
            k = int'(dec_iq_id);
            m_valid[k] = 1'b1;
            m_rd[k]    = ren_rd;
            m_rs1[k]   = ren_rs1;
            m_rs2[k]   = ren_rs2;
            m_unit[k]  = dec_unit;
            m_wait1[k] = ren_rs1.regtype == TYPE_ROB && !ren_rs1_ready && !tag_seen(ren_rs1, fwd, ft);
            m_wait2[k] = ren_rs2.regtype == TYPE_ROB && !ren_rs2_ready && !tag_seen(ren_rs2, fwd, ft);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs(input int pi);
        int payload;
        payload = int'({issue_rd, issue_rs1, issue_rs2, issue_unit});
        check_eq("issue_e_", int'(issue_e_), (pi < 0) ? 1 : 0);
        if (pi >= 0) begin
            check_eq("issue_iq_id", int'(issue_iq_id), pi);
            check_eq("issue_payload", payload,
                     int'({m_rd[pi], m_rs1[pi], m_rs2[pi], m_unit[pi]}));
        end else begin
            check_eq("idle_iq_id", int'(issue_iq_id), 0);
            check_eq("idle_payload", payload, int'({8'd0, 8'd0, 8'd0, UNIT_NOP}));
        end
    endtask

    task automatic idle_inputs();
        add_entry_ = 1'b1;
        wb_e_      = 1'b1;
        commit_e_  = 1'b1;
        flush_     = 1'b1;
    endtask

    // One clock: check against the model, optionally against a required
    // slot (-1 = nothing issues, -2 = no directed expectation), then tick.
    task automatic cycle(input int plan);
        int pi;
        int got;
        #1;
        pi = predict_slot();
        check_outputs(pi);
        if (plan != -2) begin
            got = (issue_e_ == 1'b0) ? int'(issue_iq_id) : -1;
            check_eq("plan_slot", got, plan);
        end
        @(posedge clk);
        model_update(pi);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic dispatch(input int slot, input RegFile_t rd, input RegFile_t s1, input bit r1,
                            input RegFile_t s2, input bit r2, input ExeUnit_t u);
        add_entry_    = 1'b0;
        dec_iq_id     = 2'(slot);
        ren_rd        = rd;
        ren_rs1       = s1;
        ren_rs1_ready = r1;
        ren_rs2       = s2;
        ren_rs2_ready = r2;
        dec_unit      = u;
    endtask

    task automatic writeback(input RegFile_t t);
        wb_e_ = 1'b0;
        wb_rd = t;
    endtask

    // Called on a negedge: reset must idle the outputs without a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_clear();
        check_eq("reset_idle_e", int'(issue_e_), 1);
        check_outputs(-1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    function automatic RegFile_t rand_tag();
        if ($urandom_range(0, 9) < 6) return mk(TYPE_ROB, int'($urandom_range(0, 3)));
        return mk(RegType_t'(3'($urandom_range(0, 5))), int'($urandom_range(0, 31)));
    endfunction

    initial begin
        model_clear();
        #1;
        check_eq("por_idle_e", int'(issue_e_), 1);
        check_outputs(-1);
        @(negedge clk);
        reset = 1'b0;

        // Scenario 1: basic out-of-order issue and writeback wakeup.
        dispatch(0, mk(TYPE_ROB, 4), mk(TYPE_ROB, 0), 1'b0, mk(TYPE_IMM, 0), 1'b0, UNIT_ALU);
        cycle(-1);
        dispatch(1, mk(TYPE_GPR, 3), mk(TYPE_GPR, 1), 1'b0, mk(TYPE_GPR, 0), 1'b0, UNIT_ALU);
        cycle(-1);
        dispatch(2, mk(TYPE_GPR, 4), mk(TYPE_PC, 2), 1'b0, mk(TYPE_IMM, 1), 1'b0, UNIT_ALU);
        cycle(1);
        dispatch(3, mk(TYPE_ROB, 5), mk(TYPE_ROB, 0), 1'b0, mk(TYPE_NONE, 0), 1'b0, UNIT_ALU);
        cycle(2);
        writeback(mk(TYPE_ROB, 0));
        cycle(-1);
        cycle(0);
        cycle(3);
        cycle(-1);
        do_reset();

        // Scenario 2: ALU forwarding to a dependent entry.
        dispatch(0, mk(TYPE_ROB, 2), mk(TYPE_ROB, 0), 1'b0, mk(TYPE_NONE, 0), 1'b0, UNIT_ALU);
        cycle(-1);
        dispatch(1, mk(TYPE_ROB, 3), mk(TYPE_ROB, 2), 1'b0, mk(TYPE_NONE, 0), 1'b0, UNIT_ALU);
        cycle(-1);
        writeback(mk(TYPE_ROB, 0));
        cycle(-1);
        cycle(0);
        cycle(1);
        cycle(-1);
        do_reset();

        // Scenario 3: FPU results are not forwarded.
        dispatch(0, mk(TYPE_ROB, 2), mk(TYPE_ROB, 0), 1'b0, mk(TYPE_NONE, 0), 1'b0, UNIT_FPU);
        cycle(-1);
        dispatch(1, mk(TYPE_ROB, 3), mk(TYPE_ROB, 2), 1'b0, mk(TYPE_NONE, 0), 1'b0, UNIT_FPU);
        cycle(-1);
        writeback(mk(TYPE_ROB, 0));
        cycle(-1);
        cycle(0);
        cycle(-1);
        cycle(-1);
        writeback(mk(TYPE_ROB, 2));
        cycle(-1);
        cycle(1);
        do_reset();

        // Scenario 4: busy unit blocks issue until released.
        exe_busy.fpu = 1'b1;
        dispatch(2, mk(TYPE_FPR, 1), mk(TYPE_FPR, 2), 1'b0, mk(TYPE_FPR, 3), 1'b0, UNIT_FPU);
        cycle(-1);
        cycle(-1);
        exe_busy.fpu = 1'b0;
        cycle(2);
        cycle(-1);

        // Scenario 5a: flush discards three ready entries.
        exe_busy.alu = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dispatch(i, mk(TYPE_GPR, i), mk(TYPE_GPR, 1), 1'b0, mk(TYPE_IMM, 2), 1'b0, UNIT_ALU);
            cycle(-1);
        end
        flush_ = 1'b0;
        cycle(-1);
        exe_busy.alu = 1'b0;
        cycle(-1);
        cycle(-1);

        // Scenario 5b: reset discards three ready entries immediately.
        exe_busy.alu = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dispatch(i, mk(TYPE_GPR, i), mk(TYPE_GPR, 1), 1'b0, mk(TYPE_IMM, 2), 1'b0, UNIT_ALU);
            cycle(-1);
        end
        exe_busy.alu = 1'b0;
        #1;
        check_eq("pre_reset_issue_e", int'(issue_e_), 0);
        do_reset();
        cycle(-1);
        cycle(-1);

        // Scenario 6: commit wakeup.
        dispatch(1, mk(TYPE_GPR, 1), mk(TYPE_ROB, 5), 1'b0, mk(TYPE_NONE, 0), 1'b0, UNIT_ALU);
        cycle(-1);
        commit_e_     = 1'b0;
        commit_rob_id = 5'd5;
        commit_rd     = mk(TYPE_GPR, 1);
        cycle(-1);
        cycle(1);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                exe_busy = ExeBusy_t'(5'd0);
                for (int b = 0; b < 5; b++) begin
                    if ($urandom_range(0, 99) < 15) exe_busy[b] = 1'b1;
                end
                if ($urandom_range(0, 1) == 1) begin
                    dispatch(int'($urandom_range(0, 3)), rand_tag(), rand_tag(), 1'($urandom_range(0, 1)),
                             rand_tag(), 1'($urandom_range(0, 1)), ExeUnit_t'(3'($urandom_range(0, 5))));
                end
                if ($urandom_range(0, 9) < 3) writeback(rand_tag());
                if ($urandom_range(0, 99) < 15) begin
                    commit_e_     = 1'b0;
                    commit_rob_id = 5'($urandom_range(0, 3));
                    commit_rd     = rand_tag();
                end
                if ($urandom_range(0, 99) < 3) flush_ = 1'b0;
                cycle(-2);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
